// File: rtl/vm80a_intc.sv
// Eight-input vectored interrupt controller for the VM80A CPU: latches requests,
// applies mask and fixed priority, and supplies RST opcodes during INTA.
module vm80a_intc #(
  parameter logic [7:0] EDGE = 8'hFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] irq,
  input  logic       cpu_sync,
  input  logic [7:0] cpu_dout,
  input  logic       cpu_dbin,
  input  logic       cpu_wr_n,
  input  logic       reg_sel,
  input  logic       reg_a,
  output logic       intrq,
  output logic       vec_oe,
  output logic [7:0] vec
);

  typedef enum logic [1:0] {IDLE = 2'b00, ACK = 2'b01, DRIVE = 2'b10} state_t;

  // Lowest set bit: {none, index}; index is 3'b000 when nothing is set.
  function automatic logic [3:0] first_set(input logic [7:0] v);
    logic [3:0] r;
    r = 4'b1000;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) r = {1'b0, 3'(i)};
      else      r = r;
    end
    return r;
  endfunction

  function automatic logic [7:0] onehot(input logic [2:0] n);
    return 8'h01 << n;
  endfunction

  state_t     state_r, state_nx_s;
  logic [7:0] irq_prev_r, pending_r, isr_r, mask_r, vec_r;
  logic [2:0] idx_r;
  logic       spur_r, intrq_r, vec_oe_r, wr_act_r;

  logic [7:0] req_s, isr_set_s, isr_clr_s, pend_clr_s, pending_nx_s, isr_nx_s, mask_nx_s, vec_nx_s;
  logic [3:0] win_s, isr_top_s;
  logic [2:0] idx_nx_s;
  logic       eligible_s, inta_s, wr_act_s, wr_fire_s, ack_done_s, spur_nx_s;
  logic       intrq_nx_s, vec_oe_nx_s;

  assign req_s      = pending_r & ~mask_r;
  assign win_s      = first_set(req_s);
  assign isr_top_s  = first_set(isr_r);
  // An empty ISR reports index 0 with the none flag set, so the OR covers it.
  assign eligible_s = ~win_s[3] & (isr_top_s[3] | (win_s[2:0] < isr_top_s[2:0]));
  assign inta_s     = cpu_sync & cpu_dout[0];
  assign wr_act_s   = ~cpu_wr_n & reg_sel;
  assign wr_fire_s  = wr_act_s & ~wr_act_r;

  // Acknowledge sequencer next state.
  always_comb begin
    state_nx_s = state_r;
    ack_done_s = 1'b0;
    case (state_r)
      IDLE:    if (inta_s) state_nx_s = ACK; else state_nx_s = IDLE;
      ACK:     if (cpu_dbin) state_nx_s = DRIVE; else state_nx_s = ACK;
      DRIVE: begin
        if (!cpu_dbin) begin
          state_nx_s = IDLE;
          ack_done_s = 1'b1;
        end else begin
          state_nx_s = DRIVE;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // Pending/ISR/mask updates, latched vector selection and output next values.
  always_comb begin
    isr_set_s = (ack_done_s && !spur_r) ? onehot(idx_r) : 8'h00;
    pend_clr_s = isr_set_s & EDGE;
    isr_clr_s = 8'h00;
    if (wr_fire_s && reg_a) begin
      if (cpu_dout[3])       isr_clr_s = onehot(cpu_dout[2:0]);
      else if (!isr_top_s[3]) isr_clr_s = onehot(isr_top_s[2:0]);
      else                   isr_clr_s = 8'h00;
    end else begin
      isr_clr_s = 8'h00;
    end
    // A fresh edge beats a same-cycle clear; an ISR set beats a same-bit EOI.
    pending_nx_s = (EDGE & ((pending_r & ~pend_clr_s) | (irq & ~irq_prev_r))) | (~EDGE & irq);
    isr_nx_s     = (isr_r & ~isr_clr_s) | isr_set_s;
    mask_nx_s    = (wr_fire_s && !reg_a) ? cpu_dout : mask_r;
    if (state_r == IDLE && inta_s) begin
      idx_nx_s  = win_s[2:0];
      spur_nx_s = ~eligible_s;
    end else begin
      idx_nx_s  = idx_r;
      spur_nx_s = spur_r;
    end
    if (state_nx_s != IDLE) begin
      vec_oe_nx_s = 1'b1;
      vec_nx_s    = spur_nx_s ? 8'hFF : (8'hC7 | {2'b00, idx_nx_s, 3'b000});
    end else if (state_r == IDLE && reg_sel && cpu_dbin) begin
      vec_oe_nx_s = 1'b1;
      vec_nx_s    = reg_a ? pending_r : mask_r;
    end else begin
      vec_oe_nx_s = 1'b0;
      vec_nx_s    = 8'h00;
    end
    intrq_nx_s = eligible_s & (state_r == IDLE) & (state_nx_s == IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      irq_prev_r <= 8'h00;
      pending_r  <= 8'h00;
      isr_r      <= 8'h00;
      mask_r     <= 8'hFF;
      idx_r      <= 3'd0;
      spur_r     <= 1'b0;
      intrq_r    <= 1'b0;
      vec_oe_r   <= 1'b0;
      vec_r      <= 8'h00;
      wr_act_r   <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      irq_prev_r <= irq;
      pending_r  <= pending_nx_s;
      isr_r      <= isr_nx_s;
      mask_r     <= mask_nx_s;
      idx_r      <= idx_nx_s;
      spur_r     <= spur_nx_s;
      intrq_r    <= intrq_nx_s;
      vec_oe_r   <= vec_oe_nx_s;
      vec_r      <= vec_nx_s;
      wr_act_r   <= wr_act_s;
    end
  end

  assign intrq  = intrq_r;
  assign vec_oe = vec_oe_r;
  assign vec    = vec_r;

endmodule
